// File: rtl/alu_cmd_seq_if.sv
// Command, ALU and result signal bundle for alu_cmd_seq.
// master = the sequencer side, slave = the command source / ALU / result sink side.
interface alu_cmd_seq_if #(
  parameter int W = 8
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         cmd_acc;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   alu_in_sel;
  logic [W-1:0] alu_num1;
  logic [W-1:0] alu_num2;
  logic [6:0]   alu_out_sel;
  logic [W-1:0] alu_result;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_ready;
  logic         err_illegal;
  logic [15:0]  perf_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, alu_result, res_ready,
    output cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
           res_valid, res_data, err_illegal, perf_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, alu_result, res_ready,
    input  cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
           res_valid, res_data, err_illegal, perf_count
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command FIFO plus IDLE/ISSUE/WAIT/HOLD sequencer driving an external ALU.
// Optional feature: define ALU_SEQ_PERF_EN for a saturating completed-operation counter.
module alu_cmd_seq #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_cmd_seq_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [2:0]    OP_ILLEGAL  = 3'd7;
  localparam logic [2:0]    SEL_PERSIST = 3'b100;
  localparam logic [2:0]    SEL_LOAD    = 3'b010;
  localparam logic [2:0]    SEL_RESET   = 3'b001;

  typedef struct packed {
    logic [2:0]   op;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmdT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } stateT;

  function automatic logic [6:0] opOneHot(input logic [2:0] op);
    logic [6:0] sel;
    case (op)
      3'd0:    sel = 7'b1000000;
      3'd1:    sel = 7'b0100000;
      3'd2:    sel = 7'b0010000;
      3'd3:    sel = 7'b0001000;
      3'd4:    sel = 7'b0000100;
      3'd5:    sel = 7'b0000010;
      3'd6:    sel = 7'b0000001;
      default: sel = 7'b0000000;
    endcase
    return sel;
  endfunction

  cmdT           fifoMemR [DEPTH];
  logic [AW-1:0] wrPtrR;
  logic [AW-1:0] rdPtrR;
  logic [CW-1:0] countR;
  logic [CW-1:0] countNextS;
  logic          cmdReadyR;
  cmdT           headS;
  logic          pushS;
  logic          popS;

  stateT         stateR;
  stateT         stateNextS;
  logic [LW-1:0] latCntR;
  logic          issueS;
  logic          captureS;
  logic          releaseS;
  logic          illegalS;

  logic [2:0]    inSelR;
  logic [2:0]    inSelNextS;
  logic [W-1:0]  num1R;
  logic [W-1:0]  num2R;
  logic [6:0]    outSelR;
  logic          resValidR;
  logic [W-1:0]  resDataR;
  logic          errR;

  assign headS = fifoMemR[rdPtrR];
  assign pushS = bus.cmd_valid & cmdReadyR;

  // FIFO storage; entries are only read while occupancy says they are valid, so no reset
  always_ff @(posedge clk) begin
    if (pushS) begin
      fifoMemR[wrPtrR] <= {bus.cmd_op, bus.cmd_acc, bus.cmd_a, bus.cmd_b};
    end
  end

  // Next occupancy: a push and a pop in the same cycle cancel out
  always_comb begin
    countNextS = countR;
    case ({pushS, popS})
      2'b10:   countNextS = countR + CW'(1);
      2'b01:   countNextS = countR - CW'(1);
      default: countNextS = countR;
    endcase
  end

  // FIFO pointers, occupancy and registered ready (held low while in reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrR    <= '0;
      rdPtrR    <= '0;
      countR    <= '0;
      cmdReadyR <= 1'b0;
    end else begin
      if (pushS) begin
        wrPtrR <= wrPtrR + AW'(1);
      end
      if (popS) begin
        rdPtrR <= rdPtrR + AW'(1);
      end
      countR    <= countNextS;
      cmdReadyR <= (countNextS != FULL_COUNT);
    end
  end

  // Sequencer next-state and control strobes
  always_comb begin
    stateNextS = stateR;
    popS       = 1'b0;
    issueS     = 1'b0;
    captureS   = 1'b0;
    releaseS   = 1'b0;
    illegalS   = 1'b0;
    case (stateR)
      ST_IDLE: begin
        if (countR != CW'(0)) begin
          popS = 1'b1;
          if (headS.op == OP_ILLEGAL) begin
            illegalS   = 1'b1;
            stateNextS = ST_IDLE;
          end else begin
            issueS     = 1'b1;
            stateNextS = ST_ISSUE;
          end
        end else begin
          stateNextS = ST_IDLE;
        end
      end
      ST_ISSUE: stateNextS = ST_WAIT;
      ST_WAIT: begin
        if (latCntR == LW'(0)) begin
          captureS   = 1'b1;
          stateNextS = ST_HOLD;
        end else begin
          stateNextS = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          releaseS   = 1'b1;
          stateNextS = ST_IDLE;
        end else begin
          stateNextS = ST_HOLD;
        end
      end
      default: stateNextS = ST_IDLE;
    endcase
  end

  // ALU input select: chosen at issue, held through the ALU latency, persist otherwise
  always_comb begin
    inSelNextS = SEL_PERSIST;
    if (issueS) begin
      if (headS.acc) begin
        inSelNextS = SEL_PERSIST;
      end else begin
        inSelNextS = SEL_LOAD;
      end
    end else if ((stateR == ST_ISSUE) || ((stateR == ST_WAIT) && !captureS)) begin
      inSelNextS = inSelR;
    end else begin
      inSelNextS = SEL_PERSIST;
    end
  end

  // State register and ALU latency timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR  <= ST_IDLE;
      latCntR <= '0;
    end else begin
      stateR <= stateNextS;
      if (stateR == ST_ISSUE) begin
        latCntR <= LW'(ALU_LAT - 1);
      end else if ((stateR == ST_WAIT) && (latCntR != LW'(0))) begin
        latCntR <= latCntR - LW'(1);
      end
    end
  end

  // ALU operand/select registers; operands keep their last values between commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inSelR  <= SEL_RESET;
      num1R   <= '0;
      num2R   <= '0;
      outSelR <= 7'b0000000;
    end else begin
      inSelR <= inSelNextS;
      if (issueS) begin
        num1R   <= headS.a;
        num2R   <= headS.b;
        outSelR <= opOneHot(headS.op);
      end
    end
  end

  // Result holding register and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resValidR <= 1'b0;
      resDataR  <= '0;
      errR      <= 1'b0;
    end else begin
      if (captureS) begin
        resValidR <= 1'b1;
        resDataR  <= bus.alu_result;
      end else if (releaseS) begin
        resValidR <= 1'b0;
      end
      if (illegalS) begin
        errR <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perfCntR;

  // Completed-operation counter, saturating rather than wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfCntR <= 16'd0;
    end else if (resValidR && bus.res_ready && (perfCntR != 16'hFFFF)) begin
      perfCntR <= perfCntR + 16'd1;
    end
  end

  assign bus.perf_count = perfCntR;
`else
  assign bus.perf_count = 16'd0;
`endif

  assign bus.cmd_ready   = cmdReadyR;
  assign bus.alu_in_sel  = inSelR;
  assign bus.alu_num1    = num1R;
  assign bus.alu_num2    = num2R;
  assign bus.alu_out_sel = outSelR;
  assign bus.res_valid   = resValidR;
  assign bus.res_data    = resDataR;
  assign bus.err_illegal = errR;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: external ALU model, queue-based reference model,
// per-cycle comparison plus directed literal checks and a randomized phase.
module tb_alu_cmd_seq;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;
`ifdef ALU_SEQ_PERF_EN
  localparam int PERF_EN = 1;
`else
  localparam int PERF_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nPass   = 0;

  alu_cmd_seq_if #(.W(W)) bus ();

  alu_cmd_seq #(.W(W), .DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] aluFn(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~x;
      3'd4:    return x + y;
      3'd5:    return x - y;
      3'd6:    return x * y;
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] opFromSel(input logic [6:0] s);
    logic [2:0] op;
    op = 3'd7;
    for (int i = 0; i < 7; i++) begin
      if (s == (7'b1000000 >> i)) op = 3'(i);
    end
    return op;
  endfunction

  // ---------------- external ALU: LAT-stage pipe, persisted result register ----------
  logic [W-1:0] aluPipe [LAT];
  logic [W-1:0] aluAcc;

  function automatic logic [W-1:0] envFirst(input logic [2:0] sel, input logic [W-1:0] n1, input logic [W-1:0] acc);
    if (sel == 3'b010) return n1;
    if (sel == 3'b100) return acc;
    return '0;
  endfunction

  always @(posedge clk) begin
    aluPipe[0] <= aluFn(opFromSel(bus.alu_out_sel), envFirst(bus.alu_in_sel, bus.alu_num1, aluAcc), bus.alu_num2);
    for (int i = 1; i < LAT; i++) aluPipe[i] <= aluPipe[i-1];
    if (bus.alu_in_sel == 3'b001) aluAcc <= '0;
    else if (bus.res_valid && bus.res_ready) aluAcc <= bus.res_data;
  end
  assign bus.alu_result = aluPipe[LAT-1];

  // ---------------- reference model ---------------------------------------------------
  typedef struct {
    logic [2:0]   op;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmdT;

  cmdT          mQ[$];
  bit           mJust, mWork, mHold, mErr, mCurAcc;
  int           mTimer, mPerf;
  logic [W-1:0] mHoldData, mResult, mAcc, mNum1, mNum2;
  logic [6:0]   mSel;

  task automatic modelReset();
    mQ.delete();
    mJust = 1'b1; mWork = 1'b0; mHold = 1'b0; mErr = 1'b0; mCurAcc = 1'b0;
    mTimer = 0; mPerf = 0;
    mHoldData = '0; mResult = '0; mAcc = '0; mNum1 = '0; mNum2 = '0; mSel = 7'd0;
  endtask

  task automatic modelStep();
    bit  pushOk;
    cmdT c;
    if (!rst) begin
      modelReset();
    end else if (mJust) begin
      mJust = 1'b0;
    end else begin
      pushOk = bus.cmd_valid && (mQ.size() < DEPTH);
      if (mHold) begin
        if (bus.res_ready) begin
          mHold = 1'b0;
          mAcc  = mHoldData;
          if (mPerf < 65535) mPerf++;
        end
      end else if (mWork) begin
        mTimer--;
        if (mTimer == 0) begin
          mWork = 1'b0; mHold = 1'b1; mHoldData = mResult;
        end
      end else if (mQ.size() > 0) begin
        c = mQ.pop_front();
        if (c.op == 3'd7) begin
          mErr = 1'b1;
        end else begin
          mWork = 1'b1; mTimer = LAT + 1; mCurAcc = c.acc;
          mNum1 = c.a; mNum2 = c.b; mSel = 7'(7'b1000000 >> c.op);
          mResult = aluFn(c.op, c.acc ? mAcc : c.a, c.b);
        end
      end
      if (pushOk) begin
        c.op = bus.cmd_op; c.acc = bus.cmd_acc; c.a = bus.cmd_a; c.b = bus.cmd_b;
        mQ.push_back(c);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("cmd_ready",   32'(bus.cmd_ready),   32'(!mJust && (mQ.size() < DEPTH)));
    chk("res_valid",   32'(bus.res_valid),   32'(mHold));
    chk("res_data",    32'(bus.res_data),    32'(mHoldData));
    chk("err_illegal", 32'(bus.err_illegal), 32'(mErr));
    chk("alu_in_sel",  32'(bus.alu_in_sel),
        32'(mJust ? 3'b001 : (mWork ? (mCurAcc ? 3'b100 : 3'b010) : 3'b100)));
    chk("alu_num1",    32'(bus.alu_num1),    32'(mNum1));
    chk("alu_num2",    32'(bus.alu_num2),    32'(mNum2));
    chk("alu_out_sel", 32'(bus.alu_out_sel), 32'(mSel));
    chk("perf_count",  32'(bus.perf_count),  32'(PERF_EN ? mPerf : 0));
  end

  // ---------------- stimulus helpers --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushCmd(input logic [2:0] op, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_acc = acc; bus.cmd_a = a; bus.cmd_b = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b0;
    modelReset();
    bus.cmd_valid = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1);
  end

  // ---------------- directed and random scenarios -------------------------------------
  initial begin
    rst = 1'b0;
    modelReset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_acc = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_sel",    32'(bus.alu_in_sel),  32'h1);
    chk("rst_cmd_ready", 32'(bus.cmd_ready),   32'h0);
    chk("rst_res_valid", 32'(bus.res_valid),   32'h0);
    chk("rst_out_sel",   32'(bus.alu_out_sel), 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_in_sel",    32'(bus.alu_in_sel), 32'h1);
    chk("rel_cmd_ready", 32'(bus.cmd_ready),  32'h0);
    tick();
    chk("rel1_cmd_ready", 32'(bus.cmd_ready),  32'h1);
    chk("rel1_in_sel",    32'(bus.alu_in_sel), 32'h4);

    // ADD load, then SUB persisting the previous result
    bus.res_ready = 1'b1;
    pushCmd(3'd4, 1'b0, 8'h05, 8'h03);
    tick();
    chk("add_in_sel",  32'(bus.alu_in_sel),  32'h2);
    chk("add_out_sel", 32'(bus.alu_out_sel), 32'h04);
    waitValid("add_valid");
    chk("add_result", 32'(bus.res_data), 32'h08);
    tick();
    pushCmd(3'd5, 1'b1, 8'hAA, 8'h02);
    tick();
    chk("sub_in_sel",  32'(bus.alu_in_sel),  32'h4);
    chk("sub_out_sel", 32'(bus.alu_out_sel), 32'h02);
    waitValid("sub_valid");
    chk("sub_result", 32'(bus.res_data), 32'h06);
    tick();

    // Back-pressure: one command parks in HOLD, the rest fill the FIFO
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pushCmd(3'd4, 1'b0, 8'(i), 8'(16 * i));
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    bus.res_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      waitValid("drain_valid");
      chk("drain_result", 32'(bus.res_data), 32'(17 * i));
      tick();
    end

    // Illegal opcode then AND
    pushCmd(3'd7, 1'b0, 8'h00, 8'h00);
    pushCmd(3'd0, 1'b0, 8'hF0, 8'h3C);
    waitValid("and_valid");
    chk("and_result", 32'(bus.res_data), 32'h30);
    chk("err_set",    32'(bus.err_illegal), 32'h1);
    repeat (6) tick();
    chk("single_result", 32'(bus.res_valid), 32'h0);
    chk("err_sticky",    32'(bus.err_illegal), 32'h1);

    // Illegal opcode arriving while a result waits in HOLD
    bus.res_ready = 1'b0;
    pushCmd(3'd4, 1'b0, 8'h01, 8'h01);
    waitValid("hold_valid");
    pushCmd(3'd7, 1'b1, 8'h12, 8'h34);
    repeat (3) tick();
    chk("hold_kept_valid", 32'(bus.res_valid), 32'h1);
    chk("hold_kept_data",  32'(bus.res_data),  32'h02);
    bus.res_ready = 1'b1;
    repeat (3) tick();

    // Reset while the ALU result is pending
    pushCmd(3'd4, 1'b0, 8'h02, 8'h02);
    tick();
    tick();
    rst = 1'b0;
    modelReset();
    #1;
    chk("midrst_valid",  32'(bus.res_valid),  32'h0);
    chk("midrst_in_sel", 32'(bus.alu_in_sel), 32'h1);
    chk("midrst_ready",  32'(bus.cmd_ready),  32'h0);
    #1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("midrel_in_sel", 32'(bus.alu_in_sel), 32'h1);
    tick();
    chk("midrel_ready", 32'(bus.cmd_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("midrel_no_valid", 32'(bus.res_valid), 32'h0);
      tick();
    end

    // Three completed operations for the performance counter
    for (int i = 0; i < 3; i++) begin
      pushCmd(3'd1, 1'b0, 8'(i), 8'h40);
      waitValid("perf_valid");
      tick();
    end
    chk("perf_three", 32'(bus.perf_count), 32'(PERF_EN ? 3 : 0));

    // Randomized traffic with one reset in the middle
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) begin
        applyReset(2);
      end else begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        bus.cmd_acc   = 1'($urandom_range(0, 1));
        bus.cmd_a     = W'($urandom);
        bus.cmd_b     = W'($urandom);
        bus.res_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (60) tick();
    chk("final_idle_valid", 32'(bus.res_valid), 32'h0);
    chk("final_ready",      32'(bus.cmd_ready), 32'h1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
